// File: rtl/bird_pkg.sv
// Shared types and default launch constants for the bird launch controller.
package bird_pkg;

  typedef enum logic [2:0] {
    ST_READY,
    ST_CHARGING,
    ST_FIRE,
    ST_FLIGHT,
    ST_RELOAD,
    ST_EMPTY
  } launcher_state_t;

  localparam int unsigned SPEED_W = 11;

  localparam int unsigned DEF_SPEED_MIN             = 2;
  localparam int unsigned DEF_SPEED_MAX             = 40;
  localparam int unsigned DEF_SPEED_STEP            = 2;
  localparam int unsigned DEF_SHOTS_PER_LEVEL       = 3;
  localparam int unsigned DEF_RELOAD_FRAMES         = 15;
  localparam int unsigned DEF_FIRE_TIMEOUT          = 1023;
  localparam int unsigned DEF_FLIGHT_TIMEOUT_FRAMES = 255;

endpackage

// File: rtl/sof_frame_counter.sv
// Counts startOfFrame pulses since the last synchronous clear; done stays high
// once the count reaches the compare value. Saturates at all-ones.
module sof_frame_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sof,
  input  logic         clr,
  input  logic [W-1:0] target,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (sof && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt >= target);

endmodule

// File: rtl/bird_launcher.sv
// Player launch controller: charges a ping-pong launch speed from a held key,
// fires the bird, tracks the flight and enforces a per-level shot budget.
module bird_launcher
  import bird_pkg::*;
#(
  parameter int unsigned SPEED_MIN             = DEF_SPEED_MIN,
  parameter int unsigned SPEED_MAX             = DEF_SPEED_MAX,
  parameter int unsigned SPEED_STEP            = DEF_SPEED_STEP,
  parameter int unsigned SHOTS_PER_LEVEL       = DEF_SHOTS_PER_LEVEL,
  parameter int unsigned RELOAD_FRAMES         = DEF_RELOAD_FRAMES,
  parameter int unsigned FIRE_TIMEOUT          = DEF_FIRE_TIMEOUT,
  parameter int unsigned FLIGHT_TIMEOUT_FRAMES = DEF_FLIGHT_TIMEOUT_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               charge_key,
  input  logic               levelChange,
  input  logic               shoot,
  output logic               Fire_The_Bird,
  output logic [SPEED_W-1:0] initial_x_speed,
  output logic [3:0]         shots_left,
  output logic               out_of_shots,
  output logic               charging
);

  localparam int unsigned XW        = SPEED_W + 1;
  localparam int unsigned FIRE_W    = $clog2(FIRE_TIMEOUT + 1);
  localparam int unsigned FRAME_MAX = (FLIGHT_TIMEOUT_FRAMES > RELOAD_FRAMES) ?
                                      FLIGHT_TIMEOUT_FRAMES : RELOAD_FRAMES;
  localparam int unsigned FRAME_W   = $clog2(FRAME_MAX + 1);

  localparam logic [XW-1:0]      MIN_X     = XW'(SPEED_MIN);
  localparam logic [XW-1:0]      MAX_X     = XW'(SPEED_MAX);
  localparam logic [XW-1:0]      STEP_X    = XW'(SPEED_STEP);
  localparam logic [SPEED_W-1:0] MIN_S     = SPEED_W'(SPEED_MIN);
  localparam logic [SPEED_W-1:0] MAX_S     = SPEED_W'(SPEED_MAX);
  localparam logic [SPEED_W-1:0] STEP_S    = SPEED_W'(SPEED_STEP);
  localparam logic [3:0]         SHOTS_INIT = 4'(SHOTS_PER_LEVEL);
  localparam logic [FIRE_W-1:0]  FIRE_LAST = FIRE_W'(FIRE_TIMEOUT - 1);

  launcher_state_t     state;
  logic                dir_up;
  logic                key_q;
  logic                shoot_q;
  logic [FIRE_W-1:0]   fire_cnt;

  logic                key_rise;
  logic                shoot_fall;
  logic                flight_end;
  logic                frame_clr;
  logic                frame_done;
  logic [FRAME_W-1:0]  frame_target;

  logic [XW-1:0]       speed_x;
  logic [XW-1:0]       up_sum;
  logic [SPEED_W-1:0]  speed_stepped;
  logic                dir_stepped;

  assign key_rise   = charge_key && !key_q;
  assign shoot_fall = shoot_q && !shoot;
  assign flight_end = (state == ST_FLIGHT) && (shoot_fall || frame_done);

  // One counter serves both the flight timeout and the reload delay; it is
  // held clear outside those states and re-cleared on the FLIGHT->RELOAD hop.
  assign frame_clr    = levelChange || flight_end ||
                        !((state == ST_FLIGHT) || (state == ST_RELOAD));
  assign frame_target = (state == ST_FLIGHT) ? FRAME_W'(FLIGHT_TIMEOUT_FRAMES)
                                             : FRAME_W'(RELOAD_FRAMES);

  sof_frame_counter #(
    .W (FRAME_W)
  ) u_frame_cnt (
    .clk    (clk),
    .rst    (reset),
    .sof    (startOfFrame),
    .clr    (frame_clr),
    .target (frame_target),
    .done   (frame_done)
  );

  always_comb begin
    speed_x       = {1'b0, initial_x_speed};
    up_sum        = speed_x + STEP_X;
    speed_stepped = initial_x_speed;
    dir_stepped   = dir_up;
    if (dir_up) begin
      if (up_sum >= MAX_X) begin
        speed_stepped = MAX_S;
        dir_stepped   = 1'b0;
      end else begin
        speed_stepped = up_sum[SPEED_W-1:0];
      end
    end else begin
      if (speed_x <= MIN_X + STEP_X) begin
        speed_stepped = MIN_S;
        dir_stepped   = 1'b1;
      end else begin
        speed_stepped = initial_x_speed - STEP_S;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_READY;
      dir_up          <= 1'b1;
      key_q           <= 1'b0;
      shoot_q         <= 1'b0;
      fire_cnt        <= '0;
      Fire_The_Bird   <= 1'b0;
      initial_x_speed <= MIN_S;
      shots_left      <= SHOTS_INIT;
      out_of_shots    <= 1'b0;
      charging        <= 1'b0;
    end else begin
      key_q   <= charge_key;
      shoot_q <= shoot;
      if (levelChange) begin
        state           <= ST_READY;
        dir_up          <= 1'b1;
        fire_cnt        <= '0;
        Fire_The_Bird   <= 1'b0;
        initial_x_speed <= MIN_S;
        shots_left      <= SHOTS_INIT;
        out_of_shots    <= 1'b0;
        charging        <= 1'b0;
      end else begin
        unique case (state)
          ST_READY: begin
            initial_x_speed <= MIN_S;
            dir_up          <= 1'b1;
            if (shots_left == 4'd0) begin
              state        <= ST_EMPTY;
              out_of_shots <= 1'b1;
            end else if (key_rise) begin
              state    <= ST_CHARGING;
              charging <= 1'b1;
            end
          end
          ST_CHARGING: begin
            if (!charge_key) begin
              state         <= ST_FIRE;
              charging      <= 1'b0;
              Fire_The_Bird <= 1'b1;
              fire_cnt      <= '0;
            end else if (startOfFrame) begin
              initial_x_speed <= speed_stepped;
              dir_up          <= dir_stepped;
            end
          end
          ST_FIRE: begin
            // shoot is ignored in the first FIRE cycle so the command is
            // always at least two cycles wide.
            if (shoot && (fire_cnt != '0)) begin
              state         <= ST_FLIGHT;
              Fire_The_Bird <= 1'b0;
            end else if (fire_cnt == FIRE_LAST) begin
              state           <= ST_READY;
              Fire_The_Bird   <= 1'b0;
              initial_x_speed <= MIN_S;
              dir_up          <= 1'b1;
            end else begin
              fire_cnt <= fire_cnt + 1'b1;
            end
          end
          ST_FLIGHT: begin
            if (flight_end) begin
              if (shots_left <= 4'd1) begin
                shots_left   <= 4'd0;
                state        <= ST_EMPTY;
                out_of_shots <= 1'b1;
              end else begin
                shots_left <= shots_left - 4'd1;
                state      <= ST_RELOAD;
              end
            end
          end
          ST_RELOAD: begin
            if (frame_done) begin
              state           <= ST_READY;
              initial_x_speed <= MIN_S;
              dir_up          <= 1'b1;
            end
          end
          ST_EMPTY: begin
            out_of_shots <= 1'b1;
          end
          default: begin
            state <= ST_READY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bird_launcher.sv
// Directed self-checking bench for bird_launcher with default parameters.
module tb_bird_launcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        charge_key;
  logic        levelChange;
  logic        shoot;
  logic        Fire_The_Bird;
  logic [10:0] initial_x_speed;
  logic [3:0]  shots_left;
  logic        out_of_shots;
  logic        charging;

  int checks = 0;
  int errors = 0;

  bird_launcher dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .charge_key      (charge_key),
    .levelChange     (levelChange),
    .shoot           (shoot),
    .Fire_The_Bird   (Fire_The_Bird),
    .initial_x_speed (initial_x_speed),
    .shots_left      (shots_left),
    .out_of_shots    (out_of_shots),
    .charging        (charging)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_level();
    levelChange = 1'b1;
    tick();
    levelChange = 1'b0;
  endtask

  task automatic do_shot();
    charge_key = 1'b1; tick();
    charge_key = 1'b0; tick();
    tick();
    shoot = 1'b1; tick();
    shoot = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (Fire_The_Bird !== 1'b0) begin errors++; $display("FAIL reset_fire: got %0b want 0", Fire_The_Bird); end
    checks++; if (initial_x_speed !== 11'd2) begin errors++; $display("FAIL reset_speed: got %0d want 2", initial_x_speed); end
    checks++; if (shots_left !== 4'd3) begin errors++; $display("FAIL reset_shots: got %0d want 3", shots_left); end
    checks++; if (out_of_shots !== 1'b0) begin errors++; $display("FAIL reset_oos: got %0b want 0", out_of_shots); end
    checks++; if (charging !== 1'b0) begin errors++; $display("FAIL reset_charging: got %0b want 0", charging); end
    reset = 1'b0;
    tick();
    checks++; if (charging !== 1'b0) begin errors++; $display("FAIL post_reset_charging: got %0b want 0", charging); end
  endtask

  task automatic test_charge();
    charge_key = 1'b1; tick();
    checks++; if (charging !== 1'b1) begin errors++; $display("FAIL charge_start: got %0b want 1", charging); end
    repeat (5) sof_pulse();
    checks++; if (initial_x_speed !== 11'd12) begin errors++; $display("FAIL charge_speed: got %0d want 12", initial_x_speed); end
    checks++; if (Fire_The_Bird !== 1'b0) begin errors++; $display("FAIL charge_nofire: got %0b want 0", Fire_The_Bird); end
    charge_key = 1'b0; tick();
    checks++; if (Fire_The_Bird !== 1'b1) begin errors++; $display("FAIL fire_rise: got %0b want 1", Fire_The_Bird); end
    checks++; if (charging !== 1'b0) begin errors++; $display("FAIL fire_charging: got %0b want 0", charging); end
    tick(); tick();
    checks++; if (Fire_The_Bird !== 1'b1) begin errors++; $display("FAIL fire_hold: got %0b want 1", Fire_The_Bird); end
    shoot = 1'b1; tick();
    checks++; if (Fire_The_Bird !== 1'b0) begin errors++; $display("FAIL fire_drop: got %0b want 0", Fire_The_Bird); end
    checks++; if (initial_x_speed !== 11'd12) begin errors++; $display("FAIL flight_speed: got %0d want 12", initial_x_speed); end
    shoot = 1'b0; tick();
    checks++; if (shots_left !== 4'd2) begin errors++; $display("FAIL shot_dec: got %0d want 2", shots_left); end
    pulse_level();
    checks++; if (shots_left !== 4'd3) begin errors++; $display("FAIL level_restore: got %0d want 3", shots_left); end
  endtask

  task automatic test_release_sof();
    charge_key = 1'b1; tick();
    sof_pulse();
    checks++; if (initial_x_speed !== 11'd4) begin errors++; $display("FAIL rel_sof_pre: got %0d want 4", initial_x_speed); end
    charge_key = 1'b0; startOfFrame = 1'b1; tick();
    startOfFrame = 1'b0;
    checks++; if (initial_x_speed !== 11'd4) begin errors++; $display("FAIL rel_sof_speed: got %0d want 4", initial_x_speed); end
    checks++; if (Fire_The_Bird !== 1'b1) begin errors++; $display("FAIL rel_sof_fire: got %0b want 1", Fire_The_Bird); end
    pulse_level();
    checks++; if (Fire_The_Bird !== 1'b0) begin errors++; $display("FAIL level_fire: got %0b want 0", Fire_The_Bird); end
    checks++; if (initial_x_speed !== 11'd2) begin errors++; $display("FAIL level_speed: got %0d want 2", initial_x_speed); end
  endtask

  task automatic test_ping_pong();
    charge_key = 1'b1; tick();
    for (int f = 1; f <= 22; f++) begin
      sof_pulse();
      if (f == 19) begin
        checks++; if (initial_x_speed !== 11'd40) begin errors++; $display("FAIL pp_top: got %0d want 40", initial_x_speed); end
      end
      if (f == 20) begin
        checks++; if (initial_x_speed !== 11'd38) begin errors++; $display("FAIL pp_turn: got %0d want 38", initial_x_speed); end
      end
      if (f == 22) begin
        checks++; if (initial_x_speed !== 11'd34) begin errors++; $display("FAIL pp_down: got %0d want 34", initial_x_speed); end
      end
    end
    pulse_level();
    checks++; if (charging !== 1'b0) begin errors++; $display("FAIL pp_level_charging: got %0b want 0", charging); end
    charge_key = 1'b0; tick();
    checks++; if (Fire_The_Bird !== 1'b0) begin errors++; $display("FAIL pp_release_ready: got %0b want 0", Fire_The_Bird); end
  endtask

  task automatic test_refused();
    int high_cycles;
    charge_key = 1'b1; tick();
    charge_key = 1'b0; tick();
    high_cycles = 0;
    while ((Fire_The_Bird === 1'b1) && (high_cycles < 1100)) begin
      high_cycles++;
      tick();
    end
    checks++; if (high_cycles != 1023) begin errors++; $display("FAIL refused_len: got %0d want 1023", high_cycles); end
    checks++; if (shots_left !== 4'd3) begin errors++; $display("FAIL refused_shots: got %0d want 3", shots_left); end
    charge_key = 1'b1; tick();
    checks++; if (charging !== 1'b1) begin errors++; $display("FAIL refused_ready: got %0b want 1", charging); end
    pulse_level();
    charge_key = 1'b0; tick();
  endtask

  task automatic test_budget();
    for (int s = 0; s < 3; s++) begin
      do_shot();
      checks++; if (shots_left !== 4'(2 - s)) begin errors++; $display("FAIL budget_shots: got %0d want %0d", shots_left, 2 - s); end
      if (s < 2) repeat (15) sof_pulse();
    end
    checks++; if (out_of_shots !== 1'b1) begin errors++; $display("FAIL budget_empty: got %0b want 1", out_of_shots); end
    charge_key = 1'b1; tick();
    checks++; if (charging !== 1'b0) begin errors++; $display("FAIL empty_key: got %0b want 0", charging); end
    charge_key = 1'b0; tick();
    pulse_level();
    checks++; if (shots_left !== 4'd3) begin errors++; $display("FAIL budget_level_shots: got %0d want 3", shots_left); end
    checks++; if (out_of_shots !== 1'b0) begin errors++; $display("FAIL budget_level_oos: got %0b want 0", out_of_shots); end
    charge_key = 1'b1; tick();
    checks++; if (charging !== 1'b1) begin errors++; $display("FAIL budget_ready: got %0b want 1", charging); end
    pulse_level();
    charge_key = 1'b0; tick();
  endtask

  task automatic test_reload();
    do_shot();
    repeat (14) sof_pulse();
    charge_key = 1'b1; tick();
    checks++; if (charging !== 1'b0) begin errors++; $display("FAIL reload_key: got %0b want 0", charging); end
    charge_key = 1'b0; tick();
    sof_pulse();
    charge_key = 1'b1; tick();
    checks++; if (charging !== 1'b1) begin errors++; $display("FAIL reload_done: got %0b want 1", charging); end
    checks++; if (shots_left !== 4'd2) begin errors++; $display("FAIL reload_shots: got %0d want 2", shots_left); end
    pulse_level();
    charge_key = 1'b0; tick();
  endtask

  task automatic test_flight_timeout();
    charge_key = 1'b1; tick();
    charge_key = 1'b0; tick();
    tick();
    shoot = 1'b1; tick();
    checks++; if (Fire_The_Bird !== 1'b0) begin errors++; $display("FAIL to_fire_drop: got %0b want 0", Fire_The_Bird); end
    repeat (254) sof_pulse();
    checks++; if (shots_left !== 4'd3) begin errors++; $display("FAIL to_early: got %0d want 3", shots_left); end
    sof_pulse();
    checks++; if (shots_left !== 4'd2) begin errors++; $display("FAIL to_end: got %0d want 2", shots_left); end
    shoot = 1'b0; tick();
    checks++; if (shots_left !== 4'd2) begin errors++; $display("FAIL to_late_fall: got %0d want 2", shots_left); end
    pulse_level();
  endtask

  task automatic test_reset_mid_fire();
    do_shot();
    repeat (15) sof_pulse();
    charge_key = 1'b1; tick();
    sof_pulse(); sof_pulse();
    charge_key = 1'b0; tick();
    checks++; if ((Fire_The_Bird !== 1'b1) || (initial_x_speed !== 11'd6) || (shots_left !== 4'd2)) begin
      errors++; $display("FAIL rst_pre: fire=%0b speed=%0d shots=%0d want 1/6/2", Fire_The_Bird, initial_x_speed, shots_left);
    end
    reset = 1'b1;
    #2;
    checks++; if (Fire_The_Bird !== 1'b0) begin errors++; $display("FAIL rst_fire: got %0b want 0", Fire_The_Bird); end
    checks++; if (initial_x_speed !== 11'd2) begin errors++; $display("FAIL rst_speed: got %0d want 2", initial_x_speed); end
    checks++; if (shots_left !== 4'd3) begin errors++; $display("FAIL rst_shots: got %0d want 3", shots_left); end
    checks++; if ((charging !== 1'b0) || (out_of_shots !== 1'b0)) begin
      errors++; $display("FAIL rst_flags: charging=%0b oos=%0b want 0/0", charging, out_of_shots);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b0;
    charge_key   = 1'b0;
    levelChange  = 1'b0;
    shoot        = 1'b0;
    test_reset();
    test_charge();
    test_release_sof();
    test_ping_pong();
    test_refused();
    test_budget();
    test_reload();
    test_flight_timeout();
    test_reset_mid_fire();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bird_launcher.md
# bird_launcher

Player-side launch controller: the initiator of the bird fire handshake. It turns a held "charge" key into a frame-paced launch power, issues the fire command with the chosen horizontal speed to the bird motion block, then tracks the flight through `shoot`. It also enforces a per-level shot budget with a reload delay between shots, and sits between the keyboard decoder and the bird motion block.

## Interface
Parameters:
- SPEED_MIN, 2, lowest launch speed; also the idle value of `initial_x_speed`.
- SPEED_MAX, 40, highest launch speed.
- SPEED_STEP, 2, speed change per frame while charging.
- SHOTS_PER_LEVEL, 3, shot budget loaded at reset and on every level change.
- RELOAD_FRAMES, 15, frames held in RELOAD after a flight ends.
- FIRE_TIMEOUT, 1023, maximum cycles `Fire_The_Bird` is held without `shoot` rising.
- FLIGHT_TIMEOUT_FRAMES, 255, frames after which a flight is treated as ended.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- charge_key  in  1  level input, high while the launch key is held; already synchronous to clk.
- levelChange  in  1  one-cycle pulse; restarts the shot budget.
- shoot  in  1  from the bird motion block; high while the bird is in flight.
- Fire_The_Bird  out  1  fire command, registered.
- initial_x_speed  out  11  launch speed, unsigned, registered.
- shots_left  out  4  remaining shots.
- out_of_shots  out  1  high in EMPTY.
- charging  out  1  high in CHARGING; drives the power-bar display.

## Operation
- States: READY, CHARGING, FIRE, FLIGHT, RELOAD, EMPTY.
- READY:
  - `initial_x_speed = SPEED_MIN`, direction = up.
  - Rising edge of `charge_key` (key now 1, registered copy 0) → CHARGING.
  - A key held through READY entry does not start a charge; it must be released and pressed again.
- CHARGING:
  - On each `startOfFrame` with the key still held, speed ping-pongs.
  - Up: speed + STEP, clamped to SPEED_MAX; on reaching SPEED_MAX, direction flips to down.
  - Down: speed − STEP, clamped to SPEED_MIN; on reaching SPEED_MIN, direction flips to up.
  - Key low → FIRE; speed is frozen from that cycle on.
  - Key low and `startOfFrame` in the same cycle: the release wins and speed is not stepped.
- FIRE:
  - `Fire_The_Bird = 1` in every FIRE cycle; the cycle counter clears on entry.
  - `shoot == 1` → FLIGHT, and `Fire_The_Bird` drops the next cycle.
  - Counter reaches FIRE_TIMEOUT without `shoot` (launch refused) → READY; `shots_left` unchanged.
- FLIGHT:
  - `Fire_The_Bird = 0`; `initial_x_speed` holds the launched value.
  - Flight ends on `shoot` falling (registered 1 → current 0), or when FLIGHT_TIMEOUT_FRAMES `startOfFrame` pulses have elapsed since entry.
  - On flight end: `shots_left` −1. If the new value is 0 → EMPTY, else → RELOAD.
- RELOAD: after RELOAD_FRAMES `startOfFrame` pulses → READY.
- EMPTY: `out_of_shots = 1`; leaves only on `levelChange`.
- `levelChange` takes priority in every state:
  - `shots_left = SHOTS_PER_LEVEL`, next state READY.
  - Speed = SPEED_MIN, `Fire_The_Bird = 0`, frame counter cleared.
- `shots_left` never underflows. With SHOTS_PER_LEVEL = 0, the block enters EMPTY on the first cycle after reset.

## Timing
- Reset values:
  - state READY.
  - `Fire_The_Bird` 0, `initial_x_speed` SPEED_MIN.
  - `shots_left` SHOTS_PER_LEVEL, `out_of_shots` 0, `charging` 0.
  - Key and `shoot` edge registers 0.
- Reset asserted mid-flight or mid-fire: all outputs return to reset values immediately (asynchronous).
- Key rising edge at cycle n → `charging` = 1 at n+1.
- Key release at cycle n → `Fire_The_Bird` = 1 at n+1. `initial_x_speed` is stable at least one cycle before `Fire_The_Bird` rises and for the whole of FIRE and FLIGHT.
- `Fire_The_Bird` is high for at least 2 cycles, so the receiver's one-cycle-delayed edge detector always sees a rising edge.
- `shoot` rising at cycle m → `Fire_The_Bird` = 0 at m+1.
- `shoot` falling at cycle k → `shots_left` updated at k+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `bird_pkg`:
  - `launcher_state_t` enum.
  - `SPEED_W = 11`.
  - Default launch constants.
- Sub-module `sof_frame_counter`: counts `startOfFrame` pulses.
  - Inputs: synchronous clear, compare value.
  - Output: `done` level.
  - Reused by RELOAD and the FLIGHT timeout.
- Top file holds the FSM, speed ping-pong datapath, edge registers and shot counter.

## Test plan
- Charge: press key, hold 5 frames, release → `initial_x_speed` = 12, `Fire_The_Bird` rises the cycle after release; return `shoot` = 1 after 3 cycles → `Fire_The_Bird` low the next cycle.
- Ping-pong: hold 22 frames with defaults → speed reaches 40 at frame 19, then reads 34 at frame 22.
- Refused launch: never assert `shoot` → `Fire_The_Bird` high for exactly FIRE_TIMEOUT cycles, state READY, `shots_left` still 3.
- Budget: three full shots (`shoot` pulse high/low each) → `shots_left` goes 2, 1, 0; `out_of_shots` = 1; key presses are ignored; `levelChange` → `shots_left` = 3, READY.
- Reload and timeout: after a shot, key presses are ignored for 15 frames. Holding `shoot` high for 255 frames ends the flight and decrements `shots_left`.
- Reset mid-FIRE: assert reset while `Fire_The_Bird` = 1 → all outputs at reset values in the same cycle; `shots_left` = 3.
